// File: rtl/rf_wr_arb_pkg.sv
// Shared constants for the register-file write arbiter.
// Holds the requester ids, default address/data widths and the write
// counter width.
package rf_wr_arb_pkg;

  localparam int unsigned AW_DEF = 5;
  localparam int unsigned DW_DEF = 32;
  localparam int unsigned CNT_W  = 16;

  // Requester ids; also the bit positions in the one-hot grant vector.
  localparam logic REQ_CORE = 1'b0;
  localparam logic REQ_DBG  = 1'b1;

endpackage : rf_wr_arb_pkg

// File: rtl/rf_wr_arb_if.sv
// Bundle of the two requester ports plus the register-file write side.
// master: requester/consumer view (drives valid/addr/data, sees readies and
//         the register-file write outputs).
// slave : arbiter view (sees requests, drives readies and write outputs).
interface rf_wr_arb_if
  import rf_wr_arb_pkg::*;
#(
  parameter int unsigned AW = AW_DEF,
  parameter int unsigned DW = DW_DEF
);

  logic             hold;
  logic             req0_valid;
  logic [AW-1:0]    req0_addr;
  logic [DW-1:0]    req0_data;
  logic             req0_ready;
  logic             req1_valid;
  logic [AW-1:0]    req1_addr;
  logic [DW-1:0]    req1_data;
  logic             req1_ready;
  logic             RegWrite;
  logic [AW-1:0]    rc;
  logic [DW-1:0]    dc;
  logic             last_gnt;
  logic [CNT_W-1:0] wr_cnt;

  modport master (
    output hold, req0_valid, req0_addr, req0_data,
    output req1_valid, req1_addr, req1_data,
    input  req0_ready, req1_ready,
    input  RegWrite, rc, dc, last_gnt, wr_cnt
  );

  modport slave (
    input  hold, req0_valid, req0_addr, req0_data,
    input  req1_valid, req1_addr, req1_data,
    output req0_ready, req1_ready,
    output RegWrite, rc, dc, last_gnt, wr_cnt
  );

endinterface : rf_wr_arb_if

// File: rtl/rf_wr_arb_rr_arb2.sv
// Two-input grant logic: round-robin against last_gnt when rr_en=1,
// fixed priority (requester 0 highest) when rr_en=0.
// Ports: valid[1:0] requests, last_gnt id of previous winner,
//        rr_en arbitration mode, gnt[1:0] one-hot grant (combinational).
module rr_arb2
  import rf_wr_arb_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       last_gnt,
  input  logic       rr_en,
  output logic [1:0] gnt
);

  // Contention resolves to the requester that did not win last time.
  always_comb begin
    gnt = 2'b00;
    if (valid == 2'b11) begin
      if (rr_en && (last_gnt == REQ_CORE)) begin
        gnt = 2'b10;
      end else begin
        gnt = 2'b01;
      end
    end else begin
      gnt = valid;
    end
  end

endmodule : rr_arb2

// File: rtl/rf_wr_arb.sv
// Register-file write arbiter: merges the core writeback port (req0) and the
// debug/load port (req1) onto a single registered register-file write port.
// Ports: clk, rst_n (sync, active-low), hold (freeze grants),
//        reqK_valid/addr/data in, reqK_ready out (combinational),
//        RegWrite/rc/dc registered write port, last_gnt last winner id,
//        wr_cnt count of issued writes (wraps).
module rf_wr_arb
  import rf_wr_arb_pkg::*;
#(
  parameter bit          RR_EN = 1'b1,
  parameter int unsigned AW    = AW_DEF,
  parameter int unsigned DW    = DW_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hold,
  input  logic             req0_valid,
  input  logic [AW-1:0]    req0_addr,
  input  logic [DW-1:0]    req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [AW-1:0]    req1_addr,
  input  logic [DW-1:0]    req1_data,
  output logic             req1_ready,
  output logic             RegWrite,
  output logic [AW-1:0]    rc,
  output logic [DW-1:0]    dc,
  output logic             last_gnt,
  output logic [CNT_W-1:0] wr_cnt
);

  logic [1:0]       valid_c;
  logic [1:0]       gnt_c;
  logic             xfer_c;
  logic             sel_c;
  logic [AW-1:0]    addr_c;
  logic [DW-1:0]    data_c;

  logic             regwrite_d, regwrite_q;
  logic [AW-1:0]    rc_d,       rc_q;
  logic [DW-1:0]    dc_d,       dc_q;
  logic             last_gnt_d, last_gnt_q;
  logic [CNT_W-1:0] wr_cnt_d,   wr_cnt_q;

  // Requests are masked during reset and hold so no ready can rise.
  assign valid_c = (rst_n && !hold) ? {req1_valid, req0_valid} : 2'b00;

  rr_arb2 u_arb (
    .valid    (valid_c),
    .last_gnt (last_gnt_q),
    .rr_en    (RR_EN),
    .gnt      (gnt_c)
  );

  assign req0_ready = gnt_c[0];
  assign req1_ready = gnt_c[1];

  // Next-state: pick the granted payload; address 0 is accepted but dropped.
  always_comb begin
    xfer_c     = |gnt_c;
    sel_c      = gnt_c[1] ? REQ_DBG : REQ_CORE;
    addr_c     = gnt_c[1] ? req1_addr : req0_addr;
    data_c     = gnt_c[1] ? req1_data : req0_data;
    regwrite_d = 1'b0;
    rc_d       = rc_q;
    dc_d       = dc_q;
    last_gnt_d = last_gnt_q;
    wr_cnt_d   = wr_cnt_q;
    if (xfer_c) begin
      last_gnt_d = sel_c;
      if (addr_c != '0) begin
        regwrite_d = 1'b1;
        rc_d       = addr_c;
        dc_d       = data_c;
        wr_cnt_d   = wr_cnt_q + CNT_W'(1);
      end
    end
  end

  // State registers; last_gnt resets to the debug id so the core wins first.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      regwrite_q <= 1'b0;
      rc_q       <= '0;
      dc_q       <= '0;
      last_gnt_q <= REQ_DBG;
      wr_cnt_q   <= '0;
    end else begin
      regwrite_q <= regwrite_d;
      rc_q       <= rc_d;
      dc_q       <= dc_d;
      last_gnt_q <= last_gnt_d;
      wr_cnt_q   <= wr_cnt_d;
    end
  end

  assign RegWrite = regwrite_q;
  assign rc       = rc_q;
  assign dc       = dc_q;
  assign last_gnt = last_gnt_q;
  assign wr_cnt   = wr_cnt_q;

endmodule : rf_wr_arb

// File: tb/tb_rf_wr_arb.sv
// Self-checking bench for rf_wr_arb: a round-robin instance driven through
// the interface and a fixed-priority instance sharing the same requests.
module tb_rf_wr_arb;
  import rf_wr_arb_pkg::*;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  rf_wr_arb_if #(.AW(5), .DW(32)) bus ();

  logic        fp_ready0, fp_ready1, fp_regwrite, fp_last_gnt;
  logic [4:0]  fp_rc;
  logic [31:0] fp_dc;
  logic [15:0] fp_wr_cnt;

  rf_wr_arb #(.RR_EN(1'b1), .AW(5), .DW(32)) dut (
    .clk(clk), .rst_n(rst_n), .hold(bus.hold),
    .req0_valid(bus.req0_valid), .req0_addr(bus.req0_addr),
    .req0_data(bus.req0_data), .req0_ready(bus.req0_ready),
    .req1_valid(bus.req1_valid), .req1_addr(bus.req1_addr),
    .req1_data(bus.req1_data), .req1_ready(bus.req1_ready),
    .RegWrite(bus.RegWrite), .rc(bus.rc), .dc(bus.dc),
    .last_gnt(bus.last_gnt), .wr_cnt(bus.wr_cnt)
  );

  rf_wr_arb #(.RR_EN(1'b0), .AW(5), .DW(32)) dut_fp (
    .clk(clk), .rst_n(rst_n), .hold(bus.hold),
    .req0_valid(bus.req0_valid), .req0_addr(bus.req0_addr),
    .req0_data(bus.req0_data), .req0_ready(fp_ready0),
    .req1_valid(bus.req1_valid), .req1_addr(bus.req1_addr),
    .req1_data(bus.req1_data), .req1_ready(fp_ready1),
    .RegWrite(fp_regwrite), .rc(fp_rc), .dc(fp_dc),
    .last_gnt(fp_last_gnt), .wr_cnt(fp_wr_cnt)
  );

  int n_run  = 0;
  int n_fail = 0;

  // Reference model state for the round-robin instance.
  wr_t         sbq[$];
  logic        m_last = 1'b1;
  logic [15:0] m_cnt  = 16'h0;
  logic        m_pend = 1'b0;
  logic [4:0]  m_rc   = 5'd0;
  logic [31:0] m_dc   = 32'h0;
  logic [1:0]  exp_gnt;

  // One clock of scoreboarding; called just after a negedge with inputs set.
  task automatic sb_cycle();
    logic [1:0]  g;
    logic [4:0]  a;
    logic [31:0] d;
    wr_t         it;
    #1;
    g = 2'b00;
    if (rst_n && !bus.hold) begin
      if (bus.req0_valid && bus.req1_valid) g = (m_last == 1'b0) ? 2'b10 : 2'b01;
      else if (bus.req0_valid)              g = 2'b01;
      else if (bus.req1_valid)              g = 2'b10;
    end
    exp_gnt = g;
    n_run++;
    if (bus.req0_ready !== g[0]) begin
      n_fail++; $display("FAIL sb_ready0 got=%b exp=%b t=%0t", bus.req0_ready, g[0], $time);
    end
    n_run++;
    if (bus.req1_ready !== g[1]) begin
      n_fail++; $display("FAIL sb_ready1 got=%b exp=%b t=%0t", bus.req1_ready, g[1], $time);
    end
    @(posedge clk);
    m_pend = 1'b0;
    if (!rst_n) begin
      m_last = 1'b1; m_cnt = 16'h0; m_rc = 5'd0; m_dc = 32'h0;
      sbq.delete();
    end else if (g != 2'b00) begin
      m_last = g[1];
      a = g[1] ? bus.req1_addr : bus.req0_addr;
      d = g[1] ? bus.req1_data : bus.req0_data;
      if (a != 5'd0) begin
        sbq.push_back('{addr: a, data: d});
        m_cnt  = m_cnt + 16'd1;
        m_pend = 1'b1;
      end
    end
    @(negedge clk);
    n_run++;
    if (bus.RegWrite !== m_pend) begin
      n_fail++; $display("FAIL sb_regwrite got=%b exp=%b t=%0t", bus.RegWrite, m_pend, $time);
    end
    if (m_pend) begin
      n_run++;
      if (sbq.size() == 0) begin
        n_fail++; $display("FAIL sb_queue got=empty exp=entry t=%0t", $time);
      end else begin
        it = sbq.pop_front();
        m_rc = it.addr; m_dc = it.data;
      end
    end
    n_run++;
    if (bus.rc !== m_rc) begin
      n_fail++; $display("FAIL sb_rc got=%0d exp=%0d t=%0t", bus.rc, m_rc, $time);
    end
    n_run++;
    if (bus.dc !== m_dc) begin
      n_fail++; $display("FAIL sb_dc got=%h exp=%h t=%0t", bus.dc, m_dc, $time);
    end
    n_run++;
    if (bus.last_gnt !== m_last) begin
      n_fail++; $display("FAIL sb_last_gnt got=%b exp=%b t=%0t", bus.last_gnt, m_last, $time);
    end
    n_run++;
    if (bus.wr_cnt !== m_cnt) begin
      n_fail++; $display("FAIL sb_wr_cnt got=%h exp=%h t=%0t", bus.wr_cnt, m_cnt, $time);
    end
  endtask

  task automatic idle_inputs();
    bus.hold = 1'b0;
    bus.req0_valid = 1'b0; bus.req0_addr = 5'd0; bus.req0_data = 32'h0;
    bus.req1_valid = 1'b0; bus.req1_addr = 5'd0; bus.req1_data = 32'h0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    sb_cycle();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    bus.req0_valid = 1'b1; bus.req0_addr = 5'd2;
    bus.req1_valid = 1'b1; bus.req1_addr = 5'd6;
    rst_n = 1'b0;
    repeat (2) sb_cycle();
    n_run++;
    if (bus.RegWrite !== 1'b0 || bus.rc !== 5'd0 || bus.dc !== 32'h0) begin
      n_fail++; $display("FAIL reset_outputs got=%b/%0d/%h exp=0/0/0", bus.RegWrite, bus.rc, bus.dc);
    end
    n_run++;
    if (bus.last_gnt !== 1'b1 || bus.wr_cnt !== 16'h0) begin
      n_fail++; $display("FAIL reset_state got=%b/%h exp=1/0000", bus.last_gnt, bus.wr_cnt);
    end
    n_run++;
    if (fp_ready0 !== 1'b0 || fp_ready1 !== 1'b0) begin
      n_fail++; $display("FAIL reset_fp_ready got=%b%b exp=00", fp_ready1, fp_ready0);
    end
    idle_inputs();
    rst_n = 1'b1;
  endtask

  task automatic test_single_write();
    bus.req0_valid = 1'b1; bus.req0_addr = 5'd3; bus.req0_data = 32'hA5A5A5A5;
    #1;
    n_run++;
    if (bus.req0_ready !== 1'b1) begin
      n_fail++; $display("FAIL single_ready got=%b exp=1", bus.req0_ready);
    end
    sb_cycle();
    bus.req0_valid = 1'b0;
    n_run++;
    if (bus.RegWrite !== 1'b1 || bus.rc !== 5'd3 || bus.dc !== 32'hA5A5A5A5 || bus.wr_cnt !== 16'd1) begin
      n_fail++; $display("FAIL single_write got=%b/%0d/%h/%0d exp=1/3/a5a5a5a5/1",
                         bus.RegWrite, bus.rc, bus.dc, bus.wr_cnt);
    end
    sb_cycle();
    n_run++;
    if (bus.RegWrite !== 1'b0 || bus.rc !== 5'd3) begin
      n_fail++; $display("FAIL single_drop got=%b/%0d exp=0/3", bus.RegWrite, bus.rc);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] seq [4];
    seq = '{2'b01, 2'b10, 2'b01, 2'b10};
    do_reset();
    bus.req0_valid = 1'b1; bus.req0_addr = 5'd4; bus.req0_data = 32'h0000_0004;
    bus.req1_valid = 1'b1; bus.req1_addr = 5'd5; bus.req1_data = 32'h0000_0005;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_run++;
      if ({bus.req1_ready, bus.req0_ready} !== seq[i]) begin
        n_fail++; $display("FAIL rr_grant%0d got=%b exp=%b", i, {bus.req1_ready, bus.req0_ready}, seq[i]);
      end
      sb_cycle();
    end
    idle_inputs();
    n_run++;
    if (bus.last_gnt !== 1'b1) begin
      n_fail++; $display("FAIL rr_last_gnt got=%b exp=1", bus.last_gnt);
    end
  endtask

  task automatic test_fixed_prio();
    do_reset();
    bus.req0_valid = 1'b1; bus.req0_addr = 5'd4; bus.req0_data = 32'h0000_0004;
    bus.req1_valid = 1'b1; bus.req1_addr = 5'd5; bus.req1_data = 32'h0000_0005;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_run++;
      if (fp_ready0 !== 1'b1 || fp_ready1 !== 1'b0) begin
        n_fail++; $display("FAIL fp_grant%0d got=%b%b exp=01", i, fp_ready1, fp_ready0);
      end
      sb_cycle();
      n_run++;
      if (fp_regwrite !== 1'b1 || fp_rc !== 5'd4 || fp_last_gnt !== 1'b0) begin
        n_fail++; $display("FAIL fp_write%0d got=%b/%0d/%b exp=1/4/0", i, fp_regwrite, fp_rc, fp_last_gnt);
      end
    end
    idle_inputs();
    n_run++;
    if (fp_wr_cnt !== 16'd4) begin
      n_fail++; $display("FAIL fp_wr_cnt got=%0d exp=4", fp_wr_cnt);
    end
  endtask

  task automatic test_addr_zero();
    logic [15:0] cnt0;
    bus.req0_valid = 1'b1; bus.req0_addr = 5'd8; bus.req0_data = 32'h1234_5678;
    sb_cycle();
    idle_inputs();
    cnt0 = bus.wr_cnt;
    bus.req1_valid = 1'b1; bus.req1_addr = 5'd0; bus.req1_data = 32'hFFFFFFFF;
    #1;
    n_run++;
    if (bus.req1_ready !== 1'b1) begin
      n_fail++; $display("FAIL zero_ready got=%b exp=1", bus.req1_ready);
    end
    sb_cycle();
    idle_inputs();
    n_run++;
    if (bus.RegWrite !== 1'b0 || bus.wr_cnt !== cnt0 || bus.last_gnt !== 1'b1) begin
      n_fail++; $display("FAIL zero_write got=%b/%0d/%b exp=0/%0d/1", bus.RegWrite, bus.wr_cnt, bus.last_gnt, cnt0);
    end
    n_run++;
    if (bus.rc !== 5'd8 || bus.dc !== 32'h1234_5678) begin
      n_fail++; $display("FAIL zero_hold_rc got=%0d/%h exp=8/12345678", bus.rc, bus.dc);
    end
  endtask

  task automatic test_hold();
    logic lg;
    lg = m_last;
    bus.req0_valid = 1'b1; bus.req0_addr = 5'd10; bus.req0_data = 32'hAAAA_0000;
    bus.req1_valid = 1'b1; bus.req1_addr = 5'd11; bus.req1_data = 32'hBBBB_0000;
    bus.hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_run++;
      if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin
        n_fail++; $display("FAIL hold_ready%0d got=%b%b exp=00", i, bus.req1_ready, bus.req0_ready);
      end
      sb_cycle();
      n_run++;
      if (bus.RegWrite !== 1'b0 || bus.last_gnt !== lg) begin
        n_fail++; $display("FAIL hold_state%0d got=%b/%b exp=0/%b", i, bus.RegWrite, bus.last_gnt, lg);
      end
    end
    bus.hold = 1'b0;
    #1;
    n_run++;
    if (bus.req0_ready !== lg || bus.req1_ready !== ~lg) begin
      n_fail++; $display("FAIL hold_release got=%b%b exp=%b%b", bus.req1_ready, bus.req0_ready, ~lg, lg);
    end
    sb_cycle();
    idle_inputs();
    sb_cycle();
  endtask

  // Same destination from both ports: each lands once, in grant order.
  task automatic test_back_to_back();
    bus.req0_valid = 1'b1; bus.req0_addr = 5'd9; bus.req0_data = 32'hC0C0_0001;
    bus.req1_valid = 1'b1; bus.req1_addr = 5'd9; bus.req1_data = 32'hD0D0_0002;
    for (int i = 0; i < 2; i++) begin
      sb_cycle();
      if (exp_gnt[0]) bus.req0_valid = 1'b0;
      if (exp_gnt[1]) bus.req1_valid = 1'b0;
    end
    n_run++;
    if (bus.req0_valid !== 1'b0 || bus.req1_valid !== 1'b0) begin
      n_fail++; $display("FAIL b2b_both_served got=%b%b exp=00", bus.req1_valid, bus.req0_valid);
    end
    idle_inputs();
    sb_cycle();
  endtask

  // Random traffic; a requester changes its request only once served.
  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      sb_cycle();
      if (!bus.req0_valid || exp_gnt[0]) begin
        bus.req0_valid = 1'(($urandom_range(0, 3)) != 0);
        bus.req0_addr  = 5'($urandom_range(0, 31));
        bus.req0_data  = $urandom;
      end
      if (!bus.req1_valid || exp_gnt[1]) begin
        bus.req1_valid = 1'(($urandom_range(0, 2)) != 0);
        bus.req1_addr  = 5'($urandom_range(0, 31));
        bus.req1_data  = $urandom;
      end
      bus.hold = 1'($urandom_range(0, 4) == 0);
    end
    idle_inputs();
    sb_cycle();
  endtask

  task automatic test_wrap_and_reset();
    do_reset();
    bus.req0_valid = 1'b1; bus.req0_addr = 5'd1; bus.req0_data = 32'h0000_0001;
    repeat (65535) sb_cycle();
    idle_inputs();
    n_run++;
    if (bus.wr_cnt !== 16'hFFFF) begin
      n_fail++; $display("FAIL wrap_pre got=%h exp=ffff", bus.wr_cnt);
    end
    bus.req0_valid = 1'b1; bus.req0_addr = 5'd7; bus.req0_data = 32'h7777_7777;
    sb_cycle();
    idle_inputs();
    n_run++;
    if (bus.wr_cnt !== 16'h0000 || bus.RegWrite !== 1'b1 || bus.rc !== 5'd7) begin
      n_fail++; $display("FAIL wrap got=%h/%b/%0d exp=0000/1/7", bus.wr_cnt, bus.RegWrite, bus.rc);
    end
    bus.req1_valid = 1'b1; bus.req1_addr = 5'd12; bus.req1_data = 32'hDEAD_BEEF;
    sb_cycle();
    idle_inputs();
    rst_n = 1'b0;
    sb_cycle();
    rst_n = 1'b1;
    n_run++;
    if (bus.RegWrite !== 1'b0 || bus.rc !== 5'd0 || bus.wr_cnt !== 16'h0) begin
      n_fail++; $display("FAIL reset_after_xfer got=%b/%0d/%h exp=0/0/0", bus.RegWrite, bus.rc, bus.wr_cnt);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    @(negedge clk);
    test_reset();
    test_single_write();
    test_round_robin();
    test_fixed_prio();
    test_addr_zero();
    test_hold();
    test_back_to_back();
    test_random();
    test_wrap_and_reset();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule : tb_rf_wr_arb

// File: doc/rf_wr_arb.md
RF_WR_ARB -- requirements
Module: rf_wr_arb

Interface
REQ-001 The block SHALL have parameter RR_EN, default 1, meaning 1 = round-robin arbitration and 0 = fixed priority with requester 0 highest.
REQ-002 The block SHALL have parameter AW, default 5, meaning register address width (32 registers).
REQ-003 The block SHALL have parameter DW, default 32, meaning register data width.
REQ-004 The block SHALL have one clock; reset is synchronous and active-low.
REQ-005 The block SHALL have the following ports, one per line (name, direction, width, meaning):
- clk  input  1  clock; all state updates on posedge.
- rst_n  input  1  synchronous active-low reset.
- hold  input  1  freeze; no new grants while high.
- req0_valid  input  1  requester 0 (core writeback) has a write.
- req0_addr  input  AW  requester 0 destination register.
- req0_data  input  DW  requester 0 write data.
- req0_ready  output  1  requester 0 write accepted this cycle.
- req1_valid  input  1  requester 1 (debug/load port) has a write.
- req1_addr  input  AW  requester 1 destination register.
- req1_data  input  DW  requester 1 write data.
- req1_ready  output  1  requester 1 write accepted this cycle.
- RegWrite  output  1  write enable to the register file.
- rc  output  AW  write register to the register file.
- dc  output  DW  write data to the register file.
- last_gnt  output  1  id of the most recently granted requester.
- wr_cnt  output  16  count of writes issued with RegWrite=1.

Function
REQ-006 A transfer on port k SHALL occur on a posedge where reqk_valid=1 and reqk_ready=1.
REQ-007 reqk_ready SHALL be combinational and SHALL be 1 only for the single granted requester; at most one ready is high per cycle.
REQ-008 Grant is the requester with valid=1; with both valid and RR_EN=1, the grant goes to the requester not equal to last_gnt; with RR_EN=0, it goes to requester 0.
REQ-009 hold=1 SHALL force both readies to 0; last_gnt, wr_cnt and the output registers SHALL hold, except that RegWrite returns to 0 after one cycle.
REQ-010 Latency: a transfer at edge N SHALL drive RegWrite/rc/dc during cycle N..N+1 (registered outputs), so the register file writes at edge N+1.
REQ-011 RegWrite SHALL be 1 for exactly one cycle per transfer and 0 in any cycle following an edge with no transfer.
REQ-012 A transfer with addr=0 SHALL be accepted (ready=1) but SHALL leave RegWrite=0; last_gnt SHALL update and wr_cnt SHALL NOT increment.
REQ-013 last_gnt SHALL update to k on every transfer from port k and SHALL be unchanged otherwise.
REQ-014 wr_cnt SHALL increment by 1 for each transfer with addr!=0 and SHALL wrap from 0xFFFF to 0x0000.
REQ-015 When both requesters target the same address in the same cycle, only the granted one SHALL transfer; the other transfers on a later cycle, so the later write wins in the register file.
REQ-016 A requester SHALL keep valid, addr and data stable until its transfer; the block does not check this.
REQ-017 rc and dc SHALL hold their last value when RegWrite=0.

Reset
REQ-018 With rst_n=0 at a posedge: RegWrite=0, rc=0, dc=0, last_gnt=1 (so requester 0 wins first under round-robin), wr_cnt=0.
REQ-019 While rst_n=0, both readies SHALL be 0.
REQ-020 Reset asserted in the cycle after a transfer SHALL suppress the pending RegWrite; that write is lost.

Structure
REQ-021 A shared package SHALL hold the requester-id constants (REQ_CORE=0, REQ_DBG=1) and the default AW/DW.
REQ-022 The two-input round-robin/priority grant logic SHALL be a sub-module named rr_arb2 (inputs: valid pair, last_gnt, RR_EN; output: one-hot grant).

Verification
REQ-023 Only req0_valid=1 with addr=3 and data=0xA5A5A5A5 -> req0_ready=1 that cycle; next cycle RegWrite=1, rc=3, dc=0xA5A5A5A5, wr_cnt=1.
REQ-024 Both valid for 4 cycles, RR_EN=1, after reset -> grants alternate 0,1,0,1 and last_gnt ends at 1.
REQ-025 Same as REQ-024 with RR_EN=0 -> requester 0 is granted every cycle and req1_ready stays 0.
REQ-026 req1 with addr=0 and data=0xFFFFFFFF -> req1_ready=1, next cycle RegWrite=0, wr_cnt unchanged, last_gnt=1.
REQ-027 hold=1 with both valid for 3 cycles -> both readies 0 and RegWrite=0; release hold -> grant resumes per last_gnt.
REQ-028 Preload wr_cnt to 0xFFFF (via 65535 writes or force), then one write to addr 7 -> wr_cnt=0x0000; rst_n=0 the cycle after a transfer -> RegWrite=0.
